// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state type and constants for the FIFO round-robin write arbiter
package fifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_rr_write_arbiter_rr_pick.sv
// rtl/fifo_rr_write_arbiter_rr_pick.sv - combinational round-robin picker, searching upward from ptr+1
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Wrap by subtraction so a non-power-of-2 N never yields an index >= N.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// rtl/fifo_rr_write_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
// Optional per-requester beat counters with stat_clr when ARB_STATS_EN is defined.
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int WIDTH     = 8,
  parameter  int MAX_BURST = 4,
  localparam int GW        = $clog2(NUM_REQ),
  localparam int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_w_en,
  output logic [WIDTH-1:0]         fifo_din,
`ifdef ARB_STATS_EN
  input  logic                     stat_clr,
  output logic [NUM_REQ*STAT_W-1:0] stat_beats,
`endif
  output logic [GW-1:0]            grant_id,
  output logic                     busy
);

  arb_state_t    state;
  logic [GW-1:0] rr_ptr;
  logic [BW-1:0] beat_cnt;
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          in_grant;
  logic          g_valid;
  logic          g_last;
  logic          beat;
  logic          last_beat;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign in_grant  = (state == GRANT);
  assign g_valid   = req_valid[grant_id];
  assign g_last    = req_last[grant_id];
  assign beat      = in_grant && g_valid && !fifo_full;
  assign last_beat = g_last || (beat_cnt == BW'(MAX_BURST - 1));

  assign fifo_w_en = beat;
  assign fifo_din  = in_grant ? req_data[int'(grant_id)*WIDTH +: WIDTH] : '0;
  assign req_ready = (in_grant && !fifo_full) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;
  assign busy      = in_grant;

  // A full FIFO stalls the grant: no beat, beat_cnt holds, holder keeps the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= GW'(NUM_REQ - 1);
      beat_cnt <= '0;
      grant_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!g_valid || (beat && last_beat)) begin
            state    <= IDLE;
            rr_ptr   <= grant_id;
            beat_cnt <= '0;
          end else if (beat) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst || stat_clr) begin
        stat_cnt[i] <= '0;
      end else if (beat && (grant_id == GW'(i)) && (stat_cnt[i] != '1)) begin
        stat_cnt[i] <= stat_cnt[i] + STAT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    assign stat_beats[gi*STAT_W +: STAT_W] = stat_cnt[gi];
  end
`endif

endmodule

// File: doc/fifo_rr_write_arbiter.md
Name: fifo_rr_write_arbiter

Overview:
Round-robin write arbiter that lets NUM_REQ independent producers share one sync FIFO write port. Producers each present a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's write enable and data. It sits directly in front of the FIFO and uses the FIFO's full flag for backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, data width; must match the FIFO WIDTH
MAX_BURST, 4, maximum beats per grant before re-arbitration (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester data valid
req_last  input  NUM_REQ  per-requester end-of-burst marker, qualified by valid
req_data  input  NUM_REQ*WIDTH  flattened; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  NUM_REQ  per-requester ready (one-hot or zero)
fifo_full  input  1  full flag from the FIFO
fifo_w_en  output  1  FIFO write enable
fifo_din  output  WIDTH  FIFO write data
grant_id  output  $clog2(NUM_REQ)  index of the current grant holder
busy  output  1  high while in the GRANT state

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE; rr_ptr = NUM_REQ-1, so requester 0 wins first; beat_cnt = 0; grant_id = 0.
  - Outputs: req_ready = 0, fifo_w_en = 0, busy = 0. fifo_din is don't-care but driven as 0.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - When any req_valid is high, select the first asserted index searching from rr_ptr+1 upward, modulo NUM_REQ.
  - Register the selection into grant_id and go to GRANT.
  - The arbitration decision costs one cycle; no beat transfers in IDLE.
- GRANT, with g = grant_id:
  - req_ready[g] = !fifo_full; all other ready bits are 0.
  - fifo_w_en = req_valid[g] && !fifo_full; fifo_din = req_data[g].
  - These three outputs are combinational from registered state and inputs.
  - A beat is valid && ready for requester g; each beat increments beat_cnt.
  - Release the grant (next state IDLE, rr_ptr <= g, beat_cnt <= 0) on any of:
    - a beat with req_last[g] = 1;
    - a beat that makes beat_cnt reach MAX_BURST;
    - req_valid[g] = 0 in any GRANT cycle (requester idle).
- fifo_full high in GRANT: stall. No beat occurs, beat_cnt holds, and the grant is retained.
- Fairness: after a release, the released requester is lowest priority in the next arbitration.
- A requester asserting valid and never last is still bounded to MAX_BURST beats.
- Dwell: back-to-back grants take at least one IDLE cycle between bursts.
- No data is ever written when fifo_full = 1, and never for a requester other than grant_id.
- beat_cnt width is $clog2(MAX_BURST+1).
- rr_ptr and grant_id wrap modulo NUM_REQ. Non-power-of-2 NUM_REQ must never select an index >= NUM_REQ.
- Reset mid-burst: the burst is abandoned and state returns to the reset values above. Producers re-present their data.

Optional Feature:
ARB_STATS_EN
- Defined:
  - Adds output port stat_beats (NUM_REQ*16 bits, flattened).
  - One 16-bit counter per requester, incremented on each granted beat. Counters saturate at 0xFFFF and clear on rst.
  - Adds input stat_clr (1 bit), which synchronously zeroes all counters. stat_clr takes priority over an increment in the same cycle.
- Not defined: neither port exists, no counter logic is present, and behaviour is otherwise identical.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - the STAT_W = 16 constant.
- One sub-module, rr_pick: a combinational round-robin priority picker.
  - Parameter N.
  - Inputs req[N] and ptr; outputs found and idx.
  - Instantiated once in the arbiter.

Test Plan:
- Reset, then req_valid=0001 with req_last on the 3rd beat, FIFO empty:
  - grant_id=0 on cycle 2;
  - exactly 3 fifo_w_en pulses with the data in order;
  - busy drops after the last beat;
  - rr_ptr=0.
- All 4 valid continuously, never last, MAX_BURST=4: grants go 0,1,2,3,0; each grant writes exactly 4 beats with one IDLE cycle between grants.
- Requester 1 bursting while fifo_full toggles 1,1,0,1,0: fifo_w_en is high only when full=0, the 2 beats are accepted, and beat_cnt holds during the stalls.
- Requester 2 drops valid mid-burst after 2 beats: the grant is released, and the next IDLE picks requester 3 if valid (searching from 3).
- rst asserted in the 2nd beat of a burst: all outputs are at reset values on the next cycle, no further writes occur, and requester 0 wins next.
- With ARB_STATS_EN: after the scenario-2 run of 20 beats, stat_beats shows 8,4,4,4. A stat_clr pulse zeroes all counters.
